// File: rtl/npu_pe_sequencer_if.sv
// Instruction handshake, stall and PE control bundle between an instruction
// source (master) and the PE sequencer (slave).
interface npu_pe_sequencer_if #(
    parameter int W_IN      = 8,
    parameter int MUX_WIDTH = 4
);
    logic [W_IN-1:0]      instr;
    logic                 instr_valid;
    logic                 instr_ready;
    logic                 stall;
    logic                 pe_en;
    logic                 pe_mode_sel;
    logic                 pe_reg_reset;
    logic [MUX_WIDTH-1:0] pe_mux_sel;
    logic                 busy;
    logic                 op_done;

    modport master (
        output instr, instr_valid, stall,
        input  instr_ready, pe_en, pe_mode_sel, pe_reg_reset, pe_mux_sel, busy, op_done
    );

    modport slave (
        input  instr, instr_valid, stall,
        output instr_ready, pe_en, pe_mode_sel, pe_reg_reset, pe_mux_sel, busy, op_done
    );
endinterface

// File: rtl/npu_pe_sequencer.sv
// Expands one 8-bit instruction (NOP/CLR/MAC/OUT) into per-cycle control of a
// single PE; outputs depend only on registered state plus the live stall input.
module npu_pe_sequencer #(
    parameter int W_IN      = 8,
    parameter int MUX_WIDTH = 4
) (
    input logic             clk,
    input logic             reset,
    npu_pe_sequencer_if.slave bus
);
    localparam int LEN_W = W_IN - 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_MAC  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [MUX_WIDTH-1:0] out_sel;

    logic                 pe_en_c;
    logic                 pe_mode_sel_c;
    logic                 pe_reg_reset_c;
    logic [MUX_WIDTH-1:0] pe_mux_sel_c;
    logic                 op_done_c;

    // OUT mux select is LEN[MUX_WIDTH:1], zero-filled past the top of LEN.
    for (genvar gi = 0; gi < MUX_WIDTH; gi++) begin : g_out_sel
        if (gi + 1 < LEN_W) begin : g_bit
            assign out_sel[gi] = len_q[gi+1];
        end else begin : g_zero
            assign out_sel[gi] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    len_d = bus.instr[LEN_W-1:0];
                    cnt_d = '0;
                    case (bus.instr[W_IN-1:W_IN-2])
                        2'b01:   state_d = ST_CLR;
                        2'b10:   state_d = ST_MAC;
                        2'b11:   state_d = ST_OUT;
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_CLR: state_d = ST_IDLE;
            ST_MAC: begin
                if (!bus.stall) begin
                    if (cnt_q == len_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_OUT: begin
                if (!bus.stall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // Stall gates enable and done in the same cycle; mux/mode come from held registers.
    always_comb begin
        pe_en_c        = 1'b0;
        pe_mode_sel_c  = 1'b0;
        pe_reg_reset_c = 1'b0;
        pe_mux_sel_c   = '0;
        op_done_c      = 1'b0;
        case (state_q)
            ST_CLR: begin
                pe_reg_reset_c = 1'b1;
                op_done_c      = 1'b1;
            end
            ST_MAC: begin
                pe_en_c      = !bus.stall;
                pe_mux_sel_c = cnt_q[MUX_WIDTH-1:0];
                op_done_c    = !bus.stall && (cnt_q == len_q);
            end
            ST_OUT: begin
                pe_en_c       = !bus.stall;
                pe_mode_sel_c = len_q[0];
                pe_mux_sel_c  = out_sel;
                op_done_c     = !bus.stall;
            end
            default: ;
        endcase
    end

    assign bus.instr_ready  = (state_q == ST_IDLE);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.pe_en        = pe_en_c;
    assign bus.pe_mode_sel  = pe_mode_sel_c;
    assign bus.pe_reg_reset = pe_reg_reset_c;
    assign bus.pe_mux_sel   = pe_mux_sel_c;
    assign bus.op_done      = op_done_c;
endmodule

// File: tb/tb_npu_pe_sequencer.sv
// Directed plus randomized bench for npu_pe_sequencer, checked every cycle
// against a progress-count model of the current instruction.
module tb_npu_pe_sequencer;
    logic clk;
    logic reset;

    npu_pe_sequencer_if #(.W_IN(8), .MUX_WIDTH(4)) bus ();

    npu_pe_sequencer #(.W_IN(8), .MUX_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: instruction in flight and how many unstalled cycles it has completed.
    bit m_known  = 0;
    bit m_active = 0;
    int m_op     = 0;
    int m_len    = 0;
    int m_prog   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] ins, input bit st);
        int e_en, e_mode, e_rr, e_mux, e_done;
        @(negedge clk);
        reset           = r;
        bus.instr_valid = v;
        bus.instr       = ins;
        bus.stall       = st;
        #1;
        if (m_known) begin
            e_en = 0; e_mode = 0; e_rr = 0; e_mux = 0; e_done = 0;
            if (m_active) begin
                case (m_op)
                    1: begin e_rr = 1; e_done = 1; end
                    2: begin
                        e_en   = st ? 0 : 1;
                        e_mux  = m_prog % 16;
                        e_done = (!st && m_prog == m_len) ? 1 : 0;
                    end
                    default: begin
                        e_en   = st ? 0 : 1;
                        e_done = st ? 0 : 1;
                        e_mode = m_len % 2;
                        e_mux  = (m_len / 2) % 16;
                    end
                endcase
            end
            check_eq("instr_ready",  32'(bus.instr_ready),  32'(!m_active));
            check_eq("busy",         32'(bus.busy),         32'(m_active));
            check_eq("pe_en",        32'(bus.pe_en),        32'(e_en));
            check_eq("pe_mode_sel",  32'(bus.pe_mode_sel),  32'(e_mode));
            check_eq("pe_reg_reset", 32'(bus.pe_reg_reset), 32'(e_rr));
            check_eq("pe_mux_sel",   32'(bus.pe_mux_sel),   32'(e_mux));
            check_eq("op_done",      32'(bus.op_done),      32'(e_done));
            check_eq("en_rr_excl",   32'(bus.pe_en & bus.pe_reg_reset), 32'd0);
        end
        // Advance the model across the coming rising edge.
        if (r) begin
            m_known  = 1;
            m_active = 0;
        end else if (m_known) begin
            if (!m_active) begin
                if (v) begin
                    $display("accept t=%0t instr=%02h op=%0d len=%0d", $time, ins, ins[7:6], ins[5:0]);
                    if (ins[7:6] != 2'b00) begin
                        m_active = 1;
                        m_op     = int'(ins[7:6]);
                        m_len    = int'(ins[5:0]);
                        m_prog   = 0;
                    end
                end
            end else begin
                case (m_op)
                    1: m_active = 0;
                    2: if (!st) begin
                        m_prog++;
                        if (m_prog == m_len + 1) m_active = 0;
                    end
                    default: if (!st) m_active = 0;
                endcase
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr       = 8'h40;
        bus.stall       = 1'b0;

        // Reset held with a valid instruction present.
        step(1, 1, 8'h40, 0);
        step(1, 1, 8'h40, 0);
        step(0, 0, 8'h00, 0);

        // CLR
        step(0, 1, 8'h40, 0);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // MAC LEN=19
        step(0, 1, 8'h93, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // MAC LEN=2 with stall on the 2nd MAC cycle
        step(0, 1, 8'h82, 0);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // OUT LEN=5, with one stalled cycle before it completes
        step(0, 1, 8'hC5, 0);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // NOP
        step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Boundary lengths: MAC LEN=0 and LEN=63
        step(0, 1, 8'h80, 0);
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'hBF, 0);
        for (int i = 0; i < 65; i++) step(0, 0, 8'h00, 0);

        // Abort MAC LEN=10 on its 3rd cycle, then CLR
        step(0, 1, 8'h8A, 0);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'h40, 0);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Randomized traffic with stall and rare resets
        for (int i = 0; i < 3000; i++) begin
            bit         r, v, st;
            logic [7:0] ins;
            r   = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 2) != 0);
            st  = ($urandom_range(0, 3) == 0);
            ins = 8'($urandom);
            if ($urandom_range(0, 1) == 1) ins[5:0] = 6'($urandom_range(0, 20));
            step(r, v, ins, st);
        end

        step(0, 0, 8'h00, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
